// File: rtl/psu_sw_press_meter.sv
// psu_sw_press_meter: measures how long the front-panel power switch is held, in ms.
// Debounces press and release, reports the held time once per accepted press and
// classifies it as short or long. Flags an ongoing hold once it reaches LONG_MS.
// Optional feature macro: PSU_SW_GLITCH_LOG_EN enables the rejected-press counter
// on oGlitchCnt. Without it the output is tied to 0.
module psu_sw_press_meter #(
  parameter int unsigned CLKS_PER_MS = 2000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 4000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSw_n,
  output logic             oPressed,
  output logic             oLongHold,
  output logic             oValid,
  output logic [CNT_W-1:0] oMs,
  output logic             oShort,
  output logic             oLong,
  output logic [7:0]       oGlitchCnt
);

  localparam int unsigned DEB_CLKS = DEBOUNCE_MS * CLKS_PER_MS;
  localparam int unsigned PRE_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int unsigned DEB_W    = (DEB_CLKS > 0) ? $clog2(DEB_CLKS + 1) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CLKS);
  // One extra bit so the threshold compares correctly against a saturated count.
  localparam logic [CNT_W:0]   LONG_VAL = (CNT_W + 1)'(LONG_MS);

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHeld,
    StDebRel,
    StReport
  } state_e;

  state_e             state_q;
  logic               sw_meta_q;
  logic               sw_n_q;
  logic [PRE_W-1:0]   pre_q;
  logic [PRE_W-1:0]   pre_next;
  logic [CNT_W-1:0]   ms_q;
  logic [CNT_W-1:0]   ms_next;
  logic [CNT_W-1:0]   snap_q;
  logic [DEB_W-1:0]   deb_q;
  logic               ms_tick;

  // Two-flop synchronizer for the asynchronous switch pin; idles released (high).
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sw_meta_q <= 1'b1;
      sw_n_q    <= 1'b1;
    end else begin
      sw_meta_q <= iSw_n;
      sw_n_q    <= sw_meta_q;
    end
  end

  // Next values of the prescaler and the saturating millisecond counter.
  always_comb begin
    ms_tick  = (pre_q == PRE_LAST);
    pre_next = ms_tick ? '0 : pre_q + PRE_W'(1);
    ms_next  = ms_q;
    if (ms_tick && (ms_q != {CNT_W{1'b1}})) begin
      ms_next = ms_q + CNT_W'(1);
    end
  end

  // Press/release FSM with counters and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      ms_q      <= '0;
      deb_q     <= '0;
      snap_q    <= '0;
      oPressed  <= 1'b0;
      oLongHold <= 1'b0;
      oValid    <= 1'b0;
      oMs       <= '0;
      oShort    <= 1'b0;
      oLong     <= 1'b0;
    end else begin
      oValid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pre_q <= '0;
          ms_q  <= '0;
          deb_q <= '0;
          if (!sw_n_q) begin
            state_q <= StDebPress;
          end
        end

        StDebPress: begin
          pre_q <= pre_next;
          ms_q  <= ms_next;
          if (deb_q == DEB_LAST) begin
            state_q  <= StHeld;
            deb_q    <= '0;
            oPressed <= 1'b1;
          end else if (sw_n_q) begin
            // Too short to be a press: drop it and restart from zero.
            state_q <= StIdle;
            pre_q   <= '0;
            ms_q    <= '0;
            deb_q   <= '0;
          end else begin
            deb_q <= deb_q + DEB_W'(1);
          end
        end

        StHeld: begin
          pre_q <= pre_next;
          ms_q  <= ms_next;
          if ({1'b0, ms_q} >= LONG_VAL) begin
            oLongHold <= 1'b1;
          end
          if (sw_n_q) begin
            // Snapshot includes this cycle so the count ends on DEB_REL entry.
            state_q <= StDebRel;
            snap_q  <= ms_next;
            deb_q   <= '0;
          end
        end

        StDebRel: begin
          pre_q <= pre_next;
          ms_q  <= ms_next;
          if (deb_q == DEB_LAST) begin
            state_q   <= StReport;
            oValid    <= 1'b1;
            oMs       <= snap_q;
            oShort    <= ({1'b0, snap_q} <  LONG_VAL);
            oLong     <= ({1'b0, snap_q} >= LONG_VAL);
            oPressed  <= 1'b0;
            oLongHold <= 1'b0;
          end else if (!sw_n_q) begin
            // Release bounce: the hold continues, snapshot is retaken later.
            state_q <= StHeld;
            deb_q   <= '0;
          end else begin
            deb_q <= deb_q + DEB_W'(1);
          end
        end

        StReport: begin
          state_q <= StIdle;
          pre_q   <= '0;
          ms_q    <= '0;
          deb_q   <= '0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef PSU_SW_GLITCH_LOG_EN
  logic glitch_evt;

  // Same condition as the DEB_PRESS -> IDLE transition above.
  assign glitch_evt = (state_q == StDebPress) && (deb_q != DEB_LAST) && sw_n_q;

  // Saturating count of rejected presses, cleared only by reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oGlitchCnt <= 8'd0;
    end else if (glitch_evt && (oGlitchCnt != 8'hFF)) begin
      oGlitchCnt <= oGlitchCnt + 8'd1;
    end
  end
`else
  assign oGlitchCnt = 8'd0;
`endif

endmodule

// File: doc/psu_sw_press_meter.md
# psu_sw_press_meter

- Measures how long the front-panel power switch is held, in milliseconds.
- Receiver-side counterpart of the PSU switch timing logic: the timer blocks turn an enable into a timed done pulse; this block turns an observed switch pulse back into a measured duration and classifies it.
- Sits in the PSU_SW logic between the raw switch pin and the power-sequencing FSM.
- Debounces press and release, reports the held time once per press, and flags long-press (override) holds.

## Interface

Parameters:
- CLKS_PER_MS, 2000 — iClk cycles per millisecond (2 MHz reference)
- DEBOUNCE_MS, 20 — stable time required to accept a press or a release
- LONG_MS, 4000 — hold threshold for long-press classification
- CNT_W, 16 — width of the millisecond counter and oMs

Ports:
- iClk  in  1 — 2 MHz clock
- iRst  in  1 — reset, synchronous, active-high
- iSw_n  in  1 — raw switch, active-low, asynchronous to iClk
- oPressed  out  1 — debounced press is in progress
- oLongHold  out  1 — current hold has reached LONG_MS
- oValid  out  1 — one-cycle report strobe
- oMs  out  CNT_W — measured hold time, valid with oValid, held until the next report
- oShort  out  1 — qualified by oValid: oMs < LONG_MS
- oLong  out  1 — qualified by oValid: oMs >= LONG_MS
- oGlitchCnt  out  8 — rejected-press count (see Configuration)

## Operation

Input path:
- iSw_n passes through a 2-flop synchronizer, reset to 1; its output is swN.
- Prescaler: counts 0..CLKS_PER_MS-1 and emits msTick on the terminal count.
- msCnt: CNT_W counter, +1 per msTick, saturates at all-ones.
- debCnt: counts clocks up to DEB_CLKS = DEBOUNCE_MS*CLKS_PER_MS.

FSM:
- IDLE
  - Prescaler, msCnt and debCnt held at 0.
  - swN==0 -> DEB_PRESS.
- DEB_PRESS
  - Prescaler and msCnt run; debCnt counts.
  - swN==1 before debCnt reaches DEB_CLKS -> IDLE; the glitch is recorded.
  - debCnt==DEB_CLKS -> HELD; debCnt cleared; oPressed=1.
- HELD
  - msCnt runs.
  - msCnt reaches LONG_MS -> oLongHold=1, sticky until REPORT.
  - swN==1 -> DEB_REL; snapshot <= msCnt; debCnt cleared.
- DEB_REL
  - msCnt keeps running.
  - swN==0 before debCnt reaches DEB_CLKS -> HELD; the bounce is absorbed and the snapshot is discarded.
  - debCnt==DEB_CLKS -> REPORT.
- REPORT (one cycle)
  - oValid=1, oMs<=snapshot, oShort/oLong from snapshot.
  - oPressed=0, oLongHold=0.
  - -> IDLE.

Rules:
- oMs = floor(T/CLKS_PER_MS), where T = clocks from DEB_PRESS entry to the final DEB_REL entry; saturates at 2^CNT_W-1.
- Short/long comparison uses the saturated value.
- Reset mid-operation: FSM to IDLE, all counters 0, every output 0. A press in progress is abandoned and not reported.
- Switch held low through reset release: treated as a new press once swN==0 is sampled.

## Timing

- Reset values:
  - oPressed, oLongHold, oValid, oShort, oLong: 0
  - oMs: 0
  - oGlitchCnt: 0
  - synchronizer: 1
- iSw_n edge to state change: 3 cycles (2 sync + 1 FSM).
- oPressed asserts DEB_CLKS+1 cycles after DEB_PRESS entry.
- oValid asserts DEB_CLKS+1 cycles after the final DEB_REL entry.
- oValid is exactly 1 cycle wide. At most one report per accepted press.
- oLongHold asserts on the cycle after msCnt == LONG_MS.
- oMs, oShort and oLong update on the oValid cycle and hold until the next oValid.

## Configuration

Macro: PSU_SW_GLITCH_LOG_EN
- Defined:
  - oGlitchCnt increments by 1 on every DEB_PRESS -> IDLE transition.
  - Saturates at 255.
  - Cleared only by iRst.
- Not defined:
  - oGlitchCnt is tied to 0.
  - No counter logic is synthesized.

## Test plan

All scenarios use CLKS_PER_MS=4, DEBOUNCE_MS=2 (DEB_CLKS=8), LONG_MS=10, CNT_W=16.

- Glitch: iSw_n low 5 cycles, then high.
  - oPressed stays 0; no oValid.
  - oGlitchCnt=1 with PSU_SW_GLITCH_LOG_EN; 0 without.
- Short press: iSw_n low 30 cycles, then high.
  - oPressed rises 3+9 cycles after the falling edge.
  - Single oValid with oMs=7, oShort=1, oLong=0.
  - oLongHold never asserts.
- Long press: iSw_n low 60 cycles.
  - oLongHold rises 41 cycles after DEB_PRESS entry.
  - On release: oValid with oMs=15, oLong=1, oShort=0; oLongHold clears on the oValid cycle.
- Release bounce: low 30, high 3, low 20, high.
  - Exactly one oValid.
  - oMs = floor(53/4) = 13; oLong=1.
- Reset mid-hold: iRst high for 1 cycle while in HELD.
  - Next cycle: all outputs 0.
  - Switch still held: new oPressed after 12 cycles; later release reports only post-reset time.
- Saturation: CNT_W=4, iSw_n low 100 cycles.
  - oMs=15 (all-ones); oLong=1.
